silent_interpolator: RTL and testbench

- Downstream of the silencer step calculator; consumes its per-transducer stream of target intensity, target phase and per-step update rates.
- Keeps the currently emitted intensity and phase for each transducer.
- Each frame, moves every transducer one bounded step toward its target. Phase takes the shortest path around the circle.
- Emits the smoothed stream to the PWM/duty stage in the same transducer order it arrives.

---
 rtl/silent_interpolator.sv | 80 ++++++++
 tb/tb_silent_interpolator.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/silent_interpolator.sv
// silent_interpolator: moves each transducer's intensity and phase one rate-limited step per frame toward its target
module silent_interpolator #(
  parameter int DEPTH = 249
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        DIN_VALID,
  input  logic [15:0] INTENSITY_IN,
  input  logic [15:0] PHASE_IN,
  input  logic [15:0] UPDATE_RATE_INTENSITY,
  input  logic [15:0] UPDATE_RATE_PHASE,
  output logic [15:0] INTENSITY_OUT,
  output logic [7:0]  PHASE_OUT,
  output logic        DOUT_VALID
);
  localparam int IW = $clog2(DEPTH);
  logic [IW-1:0] idx, s1_idx;
  logic [15:0] cur_i [DEPTH];
  logic [15:0] cur_p [DEPTH];
  logic        s1_v;
  logic [15:0] s1_ti, s1_tp, s1_ri, s1_rp, s1_ci, s1_cp;
  logic [15:0] nxt_i, nxt_p, d_i, fwd_d, bwd_d;
  logic [16:0] sum_i;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) idx <= '0;
    else if (DIN_VALID) idx <= (idx == IW'(DEPTH - 1)) ? '0 : idx + IW'(1);
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      s1_v   <= 1'b0;
      s1_idx <= '0;
      s1_ti  <= '0;
      s1_tp  <= '0;
      s1_ri  <= '0;
      s1_rp  <= '0;
      s1_ci  <= '0;
      s1_cp  <= '0;
    end else begin
      s1_v <= DIN_VALID;
      if (DIN_VALID) begin
        s1_idx <= idx;
        s1_ti  <= INTENSITY_IN;
        s1_tp  <= PHASE_IN;
        s1_ri  <= UPDATE_RATE_INTENSITY;
        s1_rp  <= UPDATE_RATE_PHASE;
        s1_ci  <= cur_i[idx];
        s1_cp  <= cur_p[idx];
      end
    end
  // intensity moves up with saturation at target, down without underflow; phase takes the shorter arc, tie goes backward
  always_comb begin
    sum_i = {1'b0, s1_ci} + {1'b0, s1_ri};
    d_i   = s1_ci - s1_ti;
    fwd_d = s1_tp - s1_cp;
    bwd_d = s1_cp - s1_tp;
    nxt_i = (s1_ci < s1_ti) ? ((sum_i > {1'b0, s1_ti}) ? s1_ti : sum_i[15:0])
          : (s1_ci > s1_ti) ? ((d_i > s1_ri) ? s1_ci - s1_ri : s1_ti)
          : s1_ci;
    nxt_p = (fwd_d == 16'd0) ? s1_cp
          : !fwd_d[15] ? s1_cp + ((s1_rp < fwd_d) ? s1_rp : fwd_d)
          : s1_cp - ((s1_rp < bwd_d) ? s1_rp : bwd_d);
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      for (int j = 0; j < DEPTH; j++) begin
        cur_i[j] <= '0;
        cur_p[j] <= '0;
      end
      INTENSITY_OUT <= '0;
      PHASE_OUT     <= '0;
      DOUT_VALID    <= 1'b0;
    end else begin
      DOUT_VALID <= s1_v;
      if (s1_v) begin
        cur_i[s1_idx] <= nxt_i;
        cur_p[s1_idx] <= nxt_p;
        INTENSITY_OUT <= nxt_i;
        PHASE_OUT     <= nxt_p[15:8];
      end
    end
endmodule

// File: tb/tb_silent_interpolator.sv
// tb_silent_interpolator: directed frames checked every cycle against a per-transducer arithmetic model
module tb_silent_interpolator;
  localparam int DEPTH = 249;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        DIN_VALID = 1'b0;
  logic [15:0] INTENSITY_IN = '0;
  logic [15:0] PHASE_IN = '0;
  logic [15:0] UPDATE_RATE_INTENSITY = '0;
  logic [15:0] UPDATE_RATE_PHASE = '0;
  logic [15:0] INTENSITY_OUT;
  logic [7:0]  PHASE_OUT;
  logic        DOUT_VALID;
  silent_interpolator #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .DIN_VALID(DIN_VALID),
    .INTENSITY_IN(INTENSITY_IN), .PHASE_IN(PHASE_IN),
    .UPDATE_RATE_INTENSITY(UPDATE_RATE_INTENSITY), .UPDATE_RATE_PHASE(UPDATE_RATE_PHASE),
    .INTENSITY_OUT(INTENSITY_OUT), .PHASE_OUT(PHASE_OUT), .DOUT_VALID(DOUT_VALID)
  );
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;
  int checks = 0, errors = 0;
  int ti[DEPTH], tp[DEPTH], ri[DEPTH], rp[DEPTH];
  int mi[DEPTH], mp[DEPTH], obs_i[DEPTH], obs_p[DEPTH];
  int midx = 0, last_i = 0, last_p = 0;
  typedef struct {int due; int n; int i; int p;} exp_t;
  exp_t q[$];
  exp_t e;
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  function automatic int step_i(int c, int t, int r);
    if (c < t) return (c + r < t) ? c + r : t;
    if (c > t) return (c - r > t) ? c - r : t;
    return c;
  endfunction
  function automatic int step_p(int c, int t, int r);
    int d = (t - c + 65536) % 65536;
    if (d == 0) return c;
    if (d < 32768) return (c + ((r < d) ? r : d)) % 65536;
    return (c - ((r < 65536 - d) ? r : 65536 - d) + 65536) % 65536;
  endfunction
  task automatic beat();
    int n = midx;
    exp_t x;
    DIN_VALID = 1'b1;
    INTENSITY_IN = 16'(ti[n]);
    PHASE_IN = 16'(tp[n]);
    UPDATE_RATE_INTENSITY = 16'(ri[n]);
    UPDATE_RATE_PHASE = 16'(rp[n]);
    mi[n] = step_i(mi[n], ti[n], ri[n]);
    mp[n] = step_p(mp[n], tp[n], rp[n]);
    x.due = cyc + 2;
    x.n = n;
    x.i = mi[n];
    x.p = mp[n] >> 8;
    q.push_back(x);
    midx = (n + 1) % DEPTH;
    @(posedge CLK);
    #1;
  endtask
  task automatic idle(int k);
    DIN_VALID = 1'b0;
    repeat (k) begin
      @(posedge CLK);
      #1;
    end
  endtask
  task automatic do_reset();
    RST_N = 1'b0;
    q.delete();
    midx = 0;
    last_i = 0;
    last_p = 0;
    for (int n = 0; n < DEPTH; n++) begin
      mi[n] = 0;
      mp[n] = 0;
    end
    repeat (5) begin
      DIN_VALID = ~DIN_VALID;
      @(posedge CLK);
      #1;
    end
    DIN_VALID = 1'b0;
    RST_N = 1'b1;
  endtask
  task automatic frame(int gap_at = -1, int rst_at = -1);
    for (int n = 0; n < DEPTH; n++) begin
      beat();
      if (n == gap_at) idle(7);
      if (n == rst_at) begin
        do_reset();
        return;
      end
    end
    idle(3);
  endtask
  always @(negedge CLK) begin
    if (!RST_N) begin
      chk("rst_valid", int'(DOUT_VALID), 0);
      chk("rst_intensity", int'(INTENSITY_OUT), 0);
      chk("rst_phase", int'(PHASE_OUT), 0);
    end else if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("valid", int'(DOUT_VALID), 1);
      chk("intensity", int'(INTENSITY_OUT), e.i);
      chk("phase", int'(PHASE_OUT), e.p);
      obs_i[e.n] = int'(INTENSITY_OUT);
      obs_p[e.n] = int'(PHASE_OUT);
      last_i = e.i;
      last_p = e.p;
    end else begin
      chk("idle_valid", int'(DOUT_VALID), 0);
      chk("hold_intensity", int'(INTENSITY_OUT), last_i);
      chk("hold_phase", int'(PHASE_OUT), last_p);
    end
  end
  initial begin
    for (int n = 0; n < DEPTH; n++) begin
      ti[n] = 0; tp[n] = 0; ri[n] = 0; rp[n] = 0;
      obs_i[n] = -1; obs_p[n] = -1;
    end
    do_reset();
    frame();
    chk("zero_frame_last", obs_i[DEPTH-1], 0);
    ti[5] = 'hFFFF; ri[5] = 'h1000;
    for (int f = 1; f <= 18; f++) begin
      frame();
      chk("ramp_up_t5", obs_i[5], (f < 16) ? f * 'h1000 : 'hFFFF);
    end
    ti[5] = 0; ri[5] = 'h8000;
    frame();
    chk("ramp_down1_t5", obs_i[5], 'h7FFF);
    frame();
    chk("ramp_down2_t5", obs_i[5], 0);
    tp[0] = 'hF000; rp[0] = 'h1000;
    tp[1] = 'h8000; rp[1] = 'h4000;
    frame();
    chk("preset_t0", obs_p[0], 'hF0);
    chk("tie_t1", obs_p[1], 'hC0);
    tp[0] = 'h1000; rp[0] = 'h0800;
    frame();
    chk("wrap1_t0", obs_p[0], 'hF8);
    chk("back_t1", obs_p[1], 'h80);
    tp[1] = 'h1234; rp[1] = 0;
    frame();
    chk("wrap2_t0", obs_p[0], 'h00);
    chk("frozen_t1", obs_p[1], 'h80);
    frame();
    chk("wrap3_t0", obs_p[0], 'h08);
    frame();
    chk("wrap4_t0", obs_p[0], 'h10);
    frame();
    chk("wrap_hold_t0", obs_p[0], 'h10);
    frame(100);
    ti[0] = 'h0300; ri[0] = 'h0100;
    ti[101] = 'h0500; ri[101] = 'h0500;
    frame();
    chk("after_gap_t0", obs_i[0], 'h0100);
    chk("after_gap_t101", obs_i[101], 'h0500);
    for (int n = 0; n < DEPTH; n++) begin
      ti[n] = n * 100 + 7; ri[n] = 'h200;
      tp[n] = n * 256; rp[n] = 'h300;
    end
    frame(-1, 50);
    frame();
    chk("post_rst_int_t3", obs_i[3], 307);
    chk("post_rst_int_t200", obs_i[200], 'h200);
    chk("post_rst_ph_t3", obs_p[3], 'h03);
    chk("post_rst_ph_t200", obs_p[200], 'hFD);
    chk("drain_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
